// File: rtl/ubcd_scan_pkg.sv
// Shared types and constants for the BCD/ASCII digit scan controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ubcd_scan_pkg;

  // Scan FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Bit positions in the decoder input bus DEC_D (bit i drives decoder Di).
  localparam int BIT_A   = 0;
  localparam int BIT_D   = 1;
  localparam int BIT_RBI = 2;
  localparam int BIT_BI  = 3;
  localparam int BIT_LT  = 4;
  localparam int BIT_C   = 5;
  localparam int BIT_B   = 6;

  // Idle/reset decoder drive: RBI and LT inactive (high), BI active (low), code 0.
  localparam logic [6:0] DEC_D_RST = 7'b0010100;

  // BCD decoder drive for one digit with BI asserted (blank phase).
  // BI is released separately when the digit enters its SHOW phase.
  function automatic logic [6:0] bcd_pattern(input logic [3:0] code,
                                             input logic       rbi_n,
                                             input logic       lt_n);
    logic [6:0] d;
    d          = '0;
    d[BIT_A]   = code[0];
    d[BIT_B]   = code[1];
    d[BIT_C]   = code[2];
    d[BIT_D]   = code[3];
    d[BIT_RBI] = rbi_n;
    d[BIT_BI]  = 1'b0;
    d[BIT_LT]  = lt_n;
    return d;
  endfunction

endpackage

// File: rtl/ubcd_scan_timer.sv
// Slot cycle counter: counts 0..PRESCALE-1 while the scan runs, held at 0 otherwise.
// Latency: strobes are decoded from the registered count (valid in the same cycle).
// Backpressure: none; free-running while run is high.
//
// Ports:
//   CLK, nRESET  - clock, asynchronous active-low reset
//   run          - high while a digit slot is active; low clears the count
//   blank_done   - high in the last cycle of the blank gap
//   slot_done    - high in the last cycle of the slot
module ubcd_scan_timer #(
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // The count is 0 in the first cycle of every slot: it is held at 0 while
  // idle and wraps to 0 on the edge that starts the next slot.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt <= '0;
    end else if (!run || cnt == SLOT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign blank_done = (cnt == BLANK_LAST);
  assign slot_done  = (cnt == SLOT_LAST);

endmodule

// File: rtl/ubcd_scan_controller.sv
// Time-multiplexed scan of DIGITS digit registers through one shared BCD/ASCII decoder.
// Latency: one slot of PRESCALE cycles per digit (BLANK_CYCLES gap + SHOW), MSD first.
// Backpressure: none; host writes are always accepted and never stall the scan.
//
// Ports:
//   CLK, nRESET      - clock, asynchronous active-low reset
//   SCAN_EN          - run the scan; low returns to IDLE on the next edge
//   LZS, LT          - leading-zero suppression enable, lamp test
//   WE/WADDR/WDATA   - digit register write port ([7]=ASCII mode, [6:0]=code)
//   DEC_RBO          - decoder ripple-blank output (active low), sampled at end of SHOW
//   DEC_D, DEC_ASCII - shared decoder inputs
//   DIG_EN           - one-hot digit enable, high only during SHOW
//   FRAME            - one-cycle pulse after digit 0 finishes
module ubcd_scan_controller
  import ubcd_scan_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      CLK,
  input  logic                      nRESET,
  input  logic                      SCAN_EN,
  input  logic                      LZS,
  input  logic                      LT,
  input  logic                      WE,
  input  logic [$clog2(DIGITS)-1:0] WADDR,
  input  logic [7:0]                WDATA,
  input  logic                      DEC_RBO,
  output logic [6:0]                DEC_D,
  output logic                      DEC_ASCII,
  output logic [DIGITS-1:0]         DIG_EN,
  output logic                      FRAME
);

  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0]     IDX_TOP   = IW'(DIGITS - 1);
  localparam logic [IW:0]       DIGITS_W  = (IW + 1)'(DIGITS);
  localparam logic [DIGITS-1:0] ONE_HOT_0 = DIGITS'(1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          rb_chain;

  logic [7:0]    regs [DIGITS];

  logic          blank_done;
  logic          slot_done;
  logic          run;

  logic          load_slot;
  logic [IW-1:0] next_idx;
  logic          next_rb;
  logic [7:0]    slot_data;
  logic [6:0]    pres_d;
  logic          pres_ascii;

  // ------------------------------------------------------------------
  // Digit register file
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DIGITS; i++) begin
        regs[i] <= '0;
      end
    end else if (WE && ({1'b0, WADDR} < DIGITS_W)) begin
      regs[WADDR] <= WDATA;
    end
  end

  // ------------------------------------------------------------------
  // Slot timer
  // ------------------------------------------------------------------
  assign run = SCAN_EN && (state != ST_IDLE);

  ubcd_scan_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .run        (run),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  // ------------------------------------------------------------------
  // Next-slot selection and presentation
  // ------------------------------------------------------------------
  // load_slot marks an edge that enters BLANK for a new digit. The digit
  // index and ripple-blank state for that digit are computed here so the
  // decoder inputs can be registered on the same edge.
  always_comb begin
    load_slot = 1'b0;
    next_idx  = idx;
    next_rb   = rb_chain;
    if (SCAN_EN) begin
      case (state)
        ST_IDLE: begin
          load_slot = 1'b1;
          next_idx  = IDX_TOP;
          next_rb   = LZS;
        end
        ST_SHOW: begin
          if (slot_done) begin
            load_slot = 1'b1;
            if (idx == '0) begin
              next_idx = IDX_TOP;
              next_rb  = LZS;
            end else begin
              next_idx = idx - 1'b1;
              // An ASCII digit always breaks the suppression chain; a BCD
              // digit continues it only if the decoder actually blanked it.
              next_rb  = DEC_ASCII ? 1'b0 : ~DEC_RBO;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Write-first: a write to the digit being loaded on this edge is what
  // gets presented.
  always_comb begin
    slot_data = regs[next_idx];
    if (WE && (WADDR == next_idx)) begin
      slot_data = WDATA;
    end
  end

  // Lamp test overrides ASCII mode so every segment is forced through the
  // BCD path. The least significant digit is never suppressed.
  always_comb begin
    pres_ascii = 1'b0;
    pres_d     = DEC_D_RST;
    if (slot_data[7] && !LT) begin
      pres_ascii = 1'b1;
      pres_d     = slot_data[6:0];
    end else begin
      pres_d = bcd_pattern(slot_data[3:0],
                           (next_idx == '0) ? 1'b1 : ~next_rb,
                           ~LT);
    end
  end

  // ------------------------------------------------------------------
  // Scan FSM with registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= ST_IDLE;
      idx       <= IDX_TOP;
      rb_chain  <= 1'b0;
      DEC_D     <= DEC_D_RST;
      DEC_ASCII <= 1'b0;
      DIG_EN    <= '0;
      FRAME     <= 1'b0;
    end else begin
      FRAME <= 1'b0;
      if (!SCAN_EN) begin
        state     <= ST_IDLE;
        idx       <= IDX_TOP;
        rb_chain  <= 1'b0;
        DEC_D     <= DEC_D_RST;
        DEC_ASCII <= 1'b0;
        DIG_EN    <= '0;
      end else if (load_slot) begin
        // Decoder inputs change only here, so they settle during the gap.
        state     <= ST_BLANK;
        idx       <= next_idx;
        rb_chain  <= next_rb;
        DEC_D     <= pres_d;
        DEC_ASCII <= pres_ascii;
        DIG_EN    <= '0;
        FRAME     <= (state == ST_SHOW) && (idx == '0);
      end else if (state == ST_BLANK && blank_done) begin
        state <= ST_SHOW;
        // BI is only meaningful on the BCD path; in ASCII mode bit 3 is code.
        if (!DEC_ASCII) begin
          DEC_D[BIT_BI] <= 1'b1;
        end
        DIG_EN <= ONE_HOT_0 << idx;
      end
    end
  end

endmodule
